// File: rtl/audio_input_stage.sv
// rtl/audio_input_stage.sv - I2S left-channel capture, DC removal and paced hand-off to the DFT
// Captures one 16-bit left word per frame, removes DC, and spaces output strobes by MINGAP cycles.
module audio_input_stage #(
  parameter int MINGAP  = 251,
  parameter int DCSHIFT = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bclk,
  input  logic        lrclk,
  input  logic        sdata,
  input  logic        dcBypass,
  output logic [15:0] inputSample,
  output logic        sampleReady,
  output logic [7:0]  dropCount
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SKIP  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int GW = (MINGAP > 2) ? $clog2(MINGAP) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'(MINGAP - 1);

  logic        r_bclk_s1, r_bclk_s2, r_bclk_d;
  logic        r_lr_s1, r_lr_s2, r_lr_prev;
  logic        r_sd_s1, r_sd_s2;
  logic [1:0]  r_state;
  logic [3:0]  r_bitcnt;
  logic [15:0] r_shift;
  logic signed [31:0] r_acc;
  logic [15:0] r_pend;
  logic        r_pendV;
  logic [GW-1:0] r_gap;
  logic [15:0] r_sample;
  logic        r_ready;
  logic [7:0]  r_drop;

  logic        w_rise, w_lr_edge, w_capt, w_fire;
  logic signed [15:0] w_x, w_hi, w_sat, w_y;
  logic signed [16:0] w_diff;
  logic signed [32:0] w_x33, w_acc33, w_delta, w_sum;
  logic [31:0] w_acc_next;

  assign w_rise    = r_bclk_s2 & ~r_bclk_d;
  assign w_lr_edge = r_lr_s2 ^ r_lr_prev;
  assign w_capt    = (r_state == ST_DONE);
  assign w_fire    = r_pendV && (r_gap == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bclk_s1 <= 1'b0;
      r_bclk_s2 <= 1'b0;
      r_bclk_d  <= 1'b0;
      r_lr_s1   <= 1'b0;
      r_lr_s2   <= 1'b0;
      r_sd_s1   <= 1'b0;
      r_sd_s2   <= 1'b0;
    end else begin
      r_bclk_s1 <= bclk;
      r_bclk_s2 <= r_bclk_s1;
      r_bclk_d  <= r_bclk_s2;
      r_lr_s1   <= lrclk;
      r_lr_s2   <= r_lr_s1;
      r_sd_s1   <= sdata;
      r_sd_s2   <= r_sd_s1;
    end
  end

  // r_lr_prev is lrclk as seen at the previous bclk rise, so edges are judged in bit time
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_bitcnt  <= 4'd0;
      r_shift   <= 16'h0000;
      r_lr_prev <= 1'b0;
    end else begin
      if (w_rise) r_lr_prev <= r_lr_s2;
      case (r_state)
        ST_IDLE: begin
          if (w_rise && !r_lr_s2 && r_lr_prev) r_state <= ST_SKIP;
        end
        ST_SKIP: begin
          r_bitcnt <= 4'd0;
          if (w_rise) r_state <= w_lr_edge ? ST_IDLE : ST_SHIFT;
        end
        ST_SHIFT: begin
          if (w_rise) begin
            if (w_lr_edge) begin
              r_state <= ST_IDLE;
            end else begin
              r_shift  <= {r_shift[14:0], r_sd_s2};
              r_bitcnt <= r_bitcnt + 4'd1;
              if (r_bitcnt == 4'd15) r_state <= ST_DONE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_x     = $signed(r_shift);
  assign w_hi    = r_acc[31:16];
  assign w_diff  = {w_x[15], w_x} - {w_hi[15], w_hi};
  assign w_x33   = {w_x[15], w_x, 16'h0000};
  assign w_acc33 = {r_acc[31], r_acc};
  assign w_delta = (w_x33 - w_acc33) >>> DCSHIFT;
  assign w_sum   = w_acc33 + w_delta;
  assign w_y     = dcBypass ? w_x : w_sat;

  always_comb begin
    w_sat = w_diff[15:0];
    if (w_diff[16] != w_diff[15]) w_sat = w_diff[16] ? 16'sh8000 : 16'sh7FFF;
  end

  always_comb begin
    w_acc_next = w_sum[31:0];
    if (w_sum[32] != w_sum[31]) w_acc_next = w_sum[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc <= 32'sd0;
    end else if (w_capt) begin
      r_acc <= $signed(w_acc_next);
    end
  end

  // A new word may replace pend in the very cycle pend is being presented
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend   <= 16'h0000;
      r_pendV  <= 1'b0;
      r_gap    <= '0;
      r_sample <= 16'h0000;
      r_ready  <= 1'b0;
      r_drop   <= 8'd0;
    end else begin
      if (w_capt) begin
        if (!r_pendV || w_fire) begin
          r_pend  <= w_y;
          r_pendV <= 1'b1;
        end else if (r_drop != 8'hFF) begin
          r_drop <= r_drop + 8'd1;
        end
      end else if (w_fire) begin
        r_pendV <= 1'b0;
      end
      if (w_fire) begin
        r_ready  <= 1'b1;
        r_sample <= r_pend;
        r_gap    <= GAP_LOAD;
      end else begin
        r_ready <= 1'b0;
        if (r_gap != '0) r_gap <= r_gap - 1'b1;
      end
    end
  end

  assign inputSample = r_sample;
  assign sampleReady = r_ready;
  assign dropCount   = r_drop;

endmodule

// File: tb/tb_audio_input_stage.sv
// tb/tb_audio_input_stage.sv - directed vector bench for audio_input_stage
// I2S frames are driven clk-aligned; strobes are logged at negedge with their cycle number.
module tb_audio_input_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        bclk = 1'b0;
  logic        lrclk = 1'b0;
  logic        sdata = 1'b0;
  logic        dcBypass = 1'b1;
  logic [15:0] inputSample;
  logic        sampleReady;
  logic [7:0]  dropCount;

  int cyc = 0;
  int n_checks = 0;
  int n_err = 0;
  int last16 = 0;
  int q_cyc[$];
  logic [15:0] q_val[$];

  typedef struct {
    logic [15:0] w0;
    logic [15:0] w1;
    logic        byp;
    logic [15:0] e0;
    logic [15:0] e1;
  } vec_t;
  vec_t vt[7];

  audio_input_stage #(.MINGAP(251), .DCSHIFT(4)) dut (
    .clk(clk), .rst(rst), .bclk(bclk), .lrclk(lrclk), .sdata(sdata),
    .dcBypass(dcBypass), .inputSample(inputSample), .sampleReady(sampleReady),
    .dropCount(dropCount)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (sampleReady === 1'b1) begin
      q_cyc.push_back(cyc);
      q_val.push_back(inputSample);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] qv(input int i);
    return (i >= 0 && i < q_val.size()) ? q_val[i] : 16'hxxxx;
  endfunction

  function automatic int qc(input int i);
    return (i >= 0 && i < q_cyc.size()) ? q_cyc[i] : -1;
  endfunction

  task automatic slot(input logic lr, input logic d, input int h, output int rc);
    bclk = 1'b0; lrclk = lr; sdata = d;
    repeat (h) @(posedge clk);
    #1 bclk = 1'b1;
    rc = cyc;
    repeat (h) @(posedge clk);
    #1;
  endtask

  // nr right-channel slots, then left slots k0..k1-1; data bits occupy left slots 2..17
  task automatic word(input logic [15:0] w, input int h, input int nr, input int k0, input int k1);
    int rc;
    logic d;
    for (int k = 0; k < nr; k++) slot(1'b1, 1'b0, h, rc);
    for (int k = k0; k < k1; k++) begin
      d = 1'b0;
      if (k >= 2 && k < 18) d = w[17-k];
      slot(1'b0, d, h, rc);
      if (k == 17) last16 = rc;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b0; bclk = 1'b0; lrclk = 1'b0; sdata = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    q_cyc.delete();
    q_val.delete();
  endtask

  initial begin
    int n16, ca, bad, mn, lastv, tgt;

    vt[0] = '{16'h1234, 16'hABCD, 1'b1, 16'h1234, 16'hABCD};
    vt[1] = '{16'h4000, 16'h4000, 1'b0, 16'h4000, 16'h3C00};
    vt[2] = '{16'h7FFF, 16'h8000, 1'b0, 16'h7FFF, 16'h8000};
    vt[3] = '{16'h8000, 16'h7FFF, 1'b0, 16'h8000, 16'h7FFF};
    vt[4] = '{16'h0010, 16'h0010, 1'b0, 16'h0010, 16'h000F};
    vt[5] = '{16'hFFF0, 16'h0000, 1'b0, 16'hFFF0, 16'h0001};
    vt[6] = '{16'h4000, 16'h4000, 1'b1, 16'h4000, 16'h4000};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_sample", {16'h0, inputSample}, 32'h0);
    chk("reset_ready", {31'h0, sampleReady}, 32'h0);
    chk("reset_drop", {24'h0, dropCount}, 32'h0);

    // single word at 50 MHz / 3.125 MHz, latency measured from the 16th bit rise
    do_reset();
    dcBypass = 1'b1;
    word(16'h1234, 8, 4, 0, 20);
    n16 = last16;
    idle(200);
    chk("lat_count", q_val.size(), 1);
    chk("lat_value", {16'h0, qv(0)}, 32'h1234);
    chk("lat_cycle", qc(0), n16 + 5);

    for (int i = 0; i < 7; i++) begin
      do_reset();
      dcBypass = vt[i].byp;
      word(vt[i].w0, 4, 12, 0, 20);
      word(vt[i].w1, 4, 12, 0, 20);
      idle(300);
      chk($sformatf("vec%0d_count", i), q_val.size(), 2);
      chk($sformatf("vec%0d_y0", i), {16'h0, qv(0)}, {16'h0, vt[i].e0});
      chk($sformatf("vec%0d_y1", i), {16'h0, qv(1)}, {16'h0, vt[i].e1});
      chk($sformatf("vec%0d_drop", i), {24'h0, dropCount}, 32'h0);
    end

    // C's captured cycle is placed on the cycle that consumes B
    do_reset();
    dcBypass = 1'b1;
    word(16'h1111, 2, 2, 0, 20);
    ca = last16 + 5;
    word(16'h2222, 2, 2, 0, 20);
    tgt = ca + 247 - (2 + 4 * 19);
    while (cyc < tgt) begin
      @(posedge clk);
      #1;
    end
    word(16'h3333, 2, 2, 0, 20);
    idle(600);
    chk("coin_count", q_val.size(), 3);
    chk("coin_cyc0", qc(0), ca);
    chk("coin_val1", {16'h0, qv(1)}, 32'h2222);
    chk("coin_cyc1", qc(1), ca + 251);
    chk("coin_val2", {16'h0, qv(2)}, 32'h3333);
    chk("coin_cyc2", qc(2), ca + 502);
    chk("coin_drop", {24'h0, dropCount}, 32'h0);

    do_reset();
    dcBypass = 1'b0;
    for (int i = 0; i < 160; i++) word(16'h4000, 2, 5, 0, 20);
    idle(600);
    chk("dc_first", {16'h0, qv(0)}, 32'h4000);
    chk("dc_second", {16'h0, qv(1)}, 32'h3C00);
    bad = 0;
    for (int i = 1; i < q_val.size(); i++)
      if ($signed(q_val[i]) > $signed(q_val[i-1])) bad++;
    chk("dc_monotone", bad, 0);
    lastv = (q_val.size() > 0) ? int'($signed(q_val[q_val.size()-1])) : 9999;
    chk("dc_settle", {31'h0, (lastv >= -2 && lastv <= 2)}, 32'h1);
    chk("dc_count", {31'h0, (q_val.size() >= 50)}, 32'h1);

    do_reset();
    dcBypass = 1'b1;
    for (int i = 0; i < 200; i++) word(16'h0100 + 16'(i), 2, 5, 0, 20);
    chk("drop_rising", {31'h0, (dropCount > 8'd0 && dropCount < 8'd255)}, 32'h1);
    for (int i = 200; i < 480; i++) word(16'h0100 + 16'(i), 2, 5, 0, 20);
    idle(600);
    chk("drop_sat", {24'h0, dropCount}, 32'd255);
    mn = 1000000;
    for (int i = 1; i < q_cyc.size(); i++)
      if (q_cyc[i] - q_cyc[i-1] < mn) mn = q_cyc[i] - q_cyc[i-1];
    chk("min_spacing", mn, 251);

    // reset dropped in at the 8th data bit of a left word
    word(16'h5A5A, 2, 2, 0, 10);
    #2 rst = 1'b0;
    #1;
    chk("async_sample", {16'h0, inputSample}, 32'h0);
    chk("async_ready", {31'h0, sampleReady}, 32'h0);
    chk("async_drop", {24'h0, dropCount}, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    q_cyc.delete();
    q_val.delete();
    word(16'h5A5A, 2, 0, 10, 20);
    idle(50);
    chk("rst_no_sample", q_val.size(), 0);
    word(16'hC3A5, 2, 2, 0, 20);
    idle(100);
    chk("rst_after_count", q_val.size(), 1);
    chk("rst_after_value", {16'h0, qv(0)}, 32'hC3A5);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
